// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: state codes, default field width
// and the phase-length extraction helper.
package phase_seq_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int MAX_PHASES = 16;
    localparam int MAX_CNT_W  = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_HOLD    = 3'd0;
    localparam state_t ST_IDLE    = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    // Callers zero-extend their packed length vector to the widest legal shape.
    function automatic logic [MAX_CNT_W-1:0] phase_len_at(
        input logic [MAX_PHASES*MAX_CNT_W-1:0] vec,
        input int unsigned                     idx,
        input int unsigned                     cnt_w
    );
        logic [MAX_PHASES*MAX_CNT_W-1:0] shifted;
        logic [MAX_CNT_W-1:0]            mask;
        shifted = vec >> (idx * cnt_w);
        mask    = (cnt_w >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << cnt_w) - MAX_CNT_W'(1));
        return MAX_CNT_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/phase_seq_wdog.sv
// Saturating up-counter with clear/load/enable and a terminal-count flag.
// TC_VAL may differ from MAX so callers can get a flag one count early.
module phase_seq_wdog #(
    parameter int W      = 4,
    parameter int MAX    = 10,
    parameter int TC_VAL = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != W'(MAX))) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = (count_reg == W'(TC_VAL));

endmodule

// File: rtl/phase_seq_ctrl.sv
// Run controller: reset hold, timed phase list, completion/abort/watchdog.
// Optional PHASE_SEQ_STATS_EN adds run_cycles_o and run_count_o.
module phase_seq_ctrl
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RST_HOLD   = 10,
    parameter int TIMEOUT    = 1000
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start_i,
    input  logic                                              abort_i,
    input  logic [NUM_PHASES*CNT_W-1:0]                       phase_len_i,
    output logic                                              core_rst_n_o,
    output logic                                              busy_o,
    output logic [((NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1)-1:0] phase_idx_o,
    output logic                                              phase_active_o,
    output logic                                              phase_done_o,
    output logic                                              all_done_o,
    output logic                                              timeout_o
`ifdef PHASE_SEQ_STATS_EN
    ,
    output logic [31:0]                                       run_cycles_o,
    output logic [15:0]                                       run_count_o
`endif
);

    localparam int IDX_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    state_t               state_reg;
    logic                 core_rst_n_reg, busy_reg, phase_done_reg, all_done_reg, timeout_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [CNT_W-1:0]     cnt_reg, len_reg;
    logic                 hold_tc, wd_tc, launch, last_phase;
    logic [IDX_W-1:0]     sel_idx;
    logic [CNT_W-1:0]     sel_len_raw, sel_len;
    logic [MAX_PHASES*MAX_CNT_W-1:0] len_vec;

    assign launch     = start_i && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                    (state_reg == ST_TIMEOUT));
    assign last_phase = (idx_reg == IDX_W'(NUM_PHASES - 1));

    // Length lookup serves both run launch (phase 0) and phase advance (next index).
    assign sel_idx     = launch ? '0 : idx_reg + IDX_W'(1);
    assign len_vec     = (MAX_PHASES*MAX_CNT_W)'(phase_len_i);
    assign sel_len_raw = CNT_W'(phase_len_at(len_vec, 32'(sel_idx), CNT_W));
    assign sel_len     = (sel_len_raw == '0) ? CNT_W'(1) : sel_len_raw;

    // Flag fires one count early so the release lands on the RST_HOLD-th edge.
    phase_seq_wdog #(.W(HOLD_W), .MAX(RST_HOLD), .TC_VAL(RST_HOLD - 1)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (HOLD_W'(0)),
        .en       (state_reg == ST_HOLD),
        .tc       (hold_tc)
    );

    phase_seq_wdog #(.W(WD_W), .MAX(TIMEOUT), .TC_VAL(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (launch),
        .load_val (WD_W'(1)),
        .en       (state_reg == ST_RUN),
        .tc       (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_HOLD;
            core_rst_n_reg <= 1'b0;
            busy_reg       <= 1'b0;
            phase_done_reg <= 1'b0;
            all_done_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            len_reg        <= '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (hold_tc) begin
                        state_reg      <= ST_IDLE;
                        core_rst_n_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Priority: abort, then completion, then watchdog, then phase timing.
                    if (abort_i) begin
                        state_reg      <= ST_IDLE;
                        busy_reg       <= 1'b0;
                        idx_reg        <= '0;
                        phase_done_reg <= 1'b0;
                    end else if (phase_done_reg && last_phase) begin
                        state_reg      <= ST_DONE;
                        all_done_reg   <= 1'b1;
                        busy_reg       <= 1'b0;
                        phase_done_reg <= 1'b0;
                    end else if (wd_tc) begin
                        state_reg      <= ST_TIMEOUT;
                        timeout_reg    <= 1'b1;
                        busy_reg       <= 1'b0;
                        phase_done_reg <= 1'b0;
                    end else if (phase_done_reg) begin
                        idx_reg        <= idx_reg + IDX_W'(1);
                        len_reg        <= sel_len;
                        cnt_reg        <= CNT_W'(1);
                        phase_done_reg <= (sel_len == CNT_W'(1));
                    end else begin
                        cnt_reg        <= cnt_reg + CNT_W'(1);
                        phase_done_reg <= ((cnt_reg + CNT_W'(1)) == len_reg);
                    end
                end
                default: begin
                    if (launch) begin
                        state_reg      <= ST_RUN;
                        busy_reg       <= 1'b1;
                        idx_reg        <= '0;
                        len_reg        <= sel_len;
                        cnt_reg        <= CNT_W'(1);
                        phase_done_reg <= (sel_len == CNT_W'(1));
                        all_done_reg   <= 1'b0;
                        timeout_reg    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign core_rst_n_o   = core_rst_n_reg;
    assign busy_o         = busy_reg;
    assign phase_active_o = busy_reg;
    assign phase_idx_o    = idx_reg;
    assign phase_done_o   = phase_done_reg;
    assign all_done_o     = all_done_reg;
    assign timeout_o      = timeout_reg;

`ifdef PHASE_SEQ_STATS_EN
    logic [31:0] run_cycles_reg;
    logic [15:0] run_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cycles_reg <= '0;
            run_count_reg  <= '0;
        end else begin
            if (launch) begin
                run_cycles_reg <= '0;
            end else if ((state_reg == ST_RUN) && (run_cycles_reg != '1)) begin
                run_cycles_reg <= run_cycles_reg + 32'd1;
            end
            if ((state_reg == ST_RUN) && !abort_i && phase_done_reg && last_phase &&
                (run_count_reg != 16'hFFFF)) begin
                run_count_reg <= run_count_reg + 16'd1;
            end
        end
    end

    assign run_cycles_o = run_cycles_reg;
    assign run_count_o  = run_count_reg;
`endif

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Self-checking bench: two instances (long and short watchdog) against a
// cycle-number based reference model; honours PHASE_SEQ_STATS_EN.
module tb_phase_seq_ctrl;

    localparam int NP    = 3;
    localparam int CW    = 16;
    localparam int RH    = 10;
    localparam int TO_A  = 1000;
    localparam int TO_B  = 20;
    localparam int S_HOLD = 0, S_IDLE = 1, S_RUN = 2, S_DONE = 3, S_TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [NP*CW-1:0] len_v = '0;

    logic core_a, busy_a, act_a, done_a, all_a, tmo_a;
    logic core_b, busy_b, act_b, done_b, all_b, tmo_b;
    logic [1:0] idx_a, idx_b;
    logic [7:0] obs_a, obs_b;
`ifdef PHASE_SEQ_STATS_EN
    logic [31:0] cyc_a, cyc_b;
    logic [15:0] rc_a, rc_b;
`endif

    int checks = 0, errors = 0;
    int m_st[2], m_hold[2], m_rc[2], m_ph[2], m_end[2], m_to[2], m_cyc[2], m_cnt[2];

    always #5 clk = ~clk;

    phase_seq_ctrl #(.NUM_PHASES(NP), .CNT_W(CW), .RST_HOLD(RH), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .phase_len_i(len_v),
        .core_rst_n_o(core_a), .busy_o(busy_a), .phase_idx_o(idx_a), .phase_active_o(act_a),
        .phase_done_o(done_a), .all_done_o(all_a), .timeout_o(tmo_a)
`ifdef PHASE_SEQ_STATS_EN
        , .run_cycles_o(cyc_a), .run_count_o(rc_a)
`endif
    );

    phase_seq_ctrl #(.NUM_PHASES(NP), .CNT_W(CW), .RST_HOLD(RH), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .phase_len_i(len_v),
        .core_rst_n_o(core_b), .busy_o(busy_b), .phase_idx_o(idx_b), .phase_active_o(act_b),
        .phase_done_o(done_b), .all_done_o(all_b), .timeout_o(tmo_b)
`ifdef PHASE_SEQ_STATS_EN
        , .run_cycles_o(cyc_b), .run_count_o(rc_b)
`endif
    );

    assign obs_a = {core_a, busy_a, idx_a, act_a, done_a, all_a, tmo_a};
    assign obs_b = {core_b, busy_b, idx_b, act_b, done_b, all_b, tmo_b};

    function automatic int eff_len(input int k);
        int l;
        l = int'(len_v[k*CW +: CW]);
        return (l == 0) ? 1 : l;
    endfunction

    // Model tracks absolute run-cycle numbers: each phase ends at a known cycle.
    task automatic model_update(input int d);
        if (!rst_n) begin
            m_st[d] = S_HOLD; m_hold[d] = 0; m_ph[d] = 0; m_rc[d] = 0;
            m_cyc[d] = 0; m_cnt[d] = 0;
            return;
        end
        case (m_st[d])
            S_HOLD: begin
                m_hold[d]++;
                if (m_hold[d] == RH) m_st[d] = S_IDLE;
            end
            S_RUN: begin
                m_cyc[d] = m_rc[d];
                if (abort_i) begin
                    m_st[d] = S_IDLE; m_ph[d] = 0;
                end else if (m_rc[d] == m_end[d] && m_ph[d] == NP-1) begin
                    m_st[d] = S_DONE;
                    if (m_cnt[d] < 65535) m_cnt[d]++;
                end else if (m_rc[d] >= m_to[d]) begin
                    m_st[d] = S_TMO;
                end else begin
                    if (m_rc[d] == m_end[d]) begin
                        m_ph[d]++;
                        m_end[d] = m_rc[d] + eff_len(m_ph[d]);
                    end
                    m_rc[d]++;
                end
            end
            default: begin
                if (start_i) begin
                    m_st[d] = S_RUN; m_rc[d] = 1; m_ph[d] = 0; m_end[d] = eff_len(0); m_cyc[d] = 0;
                end
            end
        endcase
    endtask

    function automatic logic [7:0] exp_vec(input int d);
        logic run;
        run = (m_st[d] == S_RUN);
        return {m_st[d] != S_HOLD, run, 2'(m_ph[d]), run, run && (m_rc[d] == m_end[d]),
                m_st[d] == S_DONE, m_st[d] == S_TMO};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
    endtask

    task automatic set_lens(input int a, input int b, input int c);
        len_v = {CW'(c), CW'(b), CW'(a)};
    endtask

    task automatic launch();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1) || obs_a !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc=%0d a=%b/%b b=%b/%b", i, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
        end
        rst_n = 1'b1;
        start_i = 1'b1;
        abort_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == RH) begin start_i = 1'b0; abort_i = 1'b0; end
            tick();
            checks++;
            if (core_a !== (i >= RH) || obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL hold_release edge=%0d core=%b required=%b a=%b/%b", i, core_a,
                         (i >= RH), obs_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_basic_run();
        int act_cnt = 0;
        set_lens(5, 10, 15);
        launch();
        for (int cyc = 1; cyc <= 31; cyc++) begin
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1) ||
                done_a !== (cyc == 5 || cyc == 15 || cyc == 30)) begin
                errors++;
                $display("FAIL basic_run cyc=%0d a=%b/%b b=%b/%b", cyc, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
            if (act_a) act_cnt++;
            if (cyc < 31) tick();
        end
        checks++;
        if (act_cnt != 30 || all_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_done active=%0d required=30 all_done=%b busy=%b", act_cnt, all_a, busy_a);
        end
    endtask

    task automatic test_timeout();
        set_lens(5, 10, 15);
        launch();
        for (int cyc = 1; cyc <= 21; cyc++) begin
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL timeout cyc=%0d a=%b/%b b=%b/%b", cyc, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
            if (cyc < 21) tick();
        end
        checks++;
        if (tmo_b !== 1'b1 || idx_b !== 2'd2 || all_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag tmo=%b idx=%0d all=%b busy=%b required 1/2/0/0", tmo_b, idx_b, all_b, busy_b);
        end
        for (int i = 0; i < 10; i++) tick();
        launch();
        checks++;
        if (tmo_b !== 1'b0 || all_b !== 1'b0 || busy_b !== 1'b1 || obs_b !== exp_vec(1)) begin
            errors++;
            $display("FAIL relaunch b=%b/%b", obs_b, exp_vec(1));
        end
        for (int i = 0; i < 31; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL relaunch_run i=%0d a=%b/%b b=%b/%b", i, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_zero_len();
        int dn = 0;
        set_lens(0, 1, 2);
        launch();
        for (int cyc = 1; cyc <= 5; cyc++) begin
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL zero_len cyc=%0d a=%b/%b b=%b/%b", cyc, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
            if (cyc <= 4 && done_a) dn++;
            if (cyc < 5) tick();
        end
        checks++;
        if (dn != 3 || all_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_done pulses=%0d required=3 all_done=%b", dn, all_a);
        end
        set_lens(4, 4, 4);
        launch();
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (cyc == 2) set_lens(9, 2, 4);
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL len_change cyc=%0d a=%b/%b b=%b/%b", cyc, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
            if (cyc < 11) tick();
        end
        checks++;
        if (all_a !== 1'b1) begin
            errors++;
            $display("FAIL len_change_done all_done=%b required=1", all_a);
        end
    endtask

    task automatic test_abort();
        set_lens(5, 10, 15);
        launch();
        for (int cyc = 1; cyc < 7; cyc++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || idx_a !== 2'd0 || all_a !== 1'b0 || tmo_a !== 1'b0 ||
            obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
            errors++;
            $display("FAIL abort a=%b/%b b=%b/%b", obs_a, exp_vec(0), obs_b, exp_vec(1));
        end
        launch();
        for (int cyc = 1; cyc < TO_B; cyc++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (tmo_b !== 1'b0 || busy_b !== 1'b0 || idx_b !== 2'd0 || obs_b !== exp_vec(1)) begin
            errors++;
            $display("FAIL abort_vs_timeout b=%b/%b", obs_b, exp_vec(1));
        end
    endtask

    task automatic test_reset_midrun();
        set_lens(5, 10, 15);
        launch();
        for (int cyc = 1; cyc < 8; cyc++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs_a !== 8'h00 || obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
            errors++;
            $display("FAIL reset_midrun a=%b required=00000000 b=%b/%b", obs_a, obs_b, exp_vec(1));
        end
        rst_n = 1'b1;
        for (int i = 0; i < RH + 1; i++) begin
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL rehold i=%0d a=%b/%b b=%b/%b", i, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            start_i = ($urandom % 8) == 0;
            abort_i = ($urandom % 40) == 0;
            rst_n   = ($urandom % 200) != 0;
            if (($urandom % 10) == 0)
                set_lens($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
            tick();
            checks++;
            if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL random i=%0d a=%b/%b b=%b/%b", i, obs_a, exp_vec(0), obs_b, exp_vec(1));
            end
        end
        start_i = 1'b0; abort_i = 1'b0; rst_n = 1'b1;
    endtask

`ifdef PHASE_SEQ_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < RH; i++) tick();
        set_lens(5, 10, 15);
        for (int r = 0; r < 2; r++) begin
            launch();
            for (int i = 0; i < 30; i++) tick();
        end
        checks++;
        if (rc_a !== 16'd2 || cyc_a !== 32'd30 || rc_a !== 16'(m_cnt[0]) || cyc_a !== 32'(m_cyc[0])) begin
            errors++;
            $display("FAIL stats run_count=%0d required=2 run_cycles=%0d required=30", rc_a, cyc_a);
        end
        checks++;
        if (rc_b !== 16'(m_cnt[1]) || cyc_b !== 32'(m_cyc[1])) begin
            errors++;
            $display("FAIL stats_b run_count=%0d required=%0d run_cycles=%0d required=%0d",
                     rc_b, m_cnt[1], cyc_b, m_cyc[1]);
        end
    endtask
`endif

    initial begin
        m_to[0] = TO_A;
        m_to[1] = TO_B;
        for (int d = 0; d < 2; d++) begin
            m_st[d] = S_HOLD; m_hold[d] = 0; m_rc[d] = 0; m_ph[d] = 0; m_end[d] = 0;
            m_cyc[d] = 0; m_cnt[d] = 0;
        end
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_timeout();
        test_zero_len();
        test_abort();
        test_reset_midrun();
        test_random();
`ifdef PHASE_SEQ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_seq_ctrl.md
Name: phase_seq_ctrl

Overview:
Synthesizable run controller that sequences a block-under-test through reset hold and a fixed list of timed phases. It ends the run on completion, abort or watchdog timeout. It sits between the top-level clock/reset and a datapath. It generates that datapath's released reset, phase strobes and pass/timeout status, so benches and on-chip self-test share one sequencing source.

Parameters:
NUM_PHASES, 3, number of timed phases per run (1..16)
CNT_W, 16, width of each phase-length field and phase counter
RST_HOLD, 10, cycles core_rst_n_o stays low after rst_n deasserts (>=1)
TIMEOUT, 1000, max cycles in RUN before watchdog fires (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start_i  in  1  level; sampled in IDLE/DONE/TIMEOUT to launch a run
abort_i  in  1  level; ends an active run
phase_len_i  in  NUM_PHASES*CNT_W  phase k length at bits [k*CNT_W +: CNT_W]
core_rst_n_o  out  1  registered released reset for the datapath
busy_o  out  1  high while in RUN
phase_idx_o  out  $clog2(NUM_PHASES) (min 1)  current phase index
phase_active_o  out  1  high every cycle of an active phase
phase_done_o  out  1  one-cycle pulse in the final cycle of each phase
all_done_o  out  1  sticky run-complete flag
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Single clock domain. All state changes on posedge clk. Outputs are registered.
- Reset (rst_n==0 at an edge): state=HOLD, hold/phase/watchdog counters=0, phase_idx_o=0. All outputs 0, including core_rst_n_o.
- HOLD: counts edges with rst_n==1. core_rst_n_o rises after the RST_HOLD-th such edge; state then goes to IDLE. start_i and abort_i are ignored.
- IDLE: start_i==1 -> RUN at the next edge.
  - phase_idx_o=0; phase 0 length is captured from phase_len_i.
  - busy_o=1, phase_active_o=1, all_done_o=0, timeout_o=0.
- RUN, phase timing:
  - Phase length L is sampled only at phase entry. Later changes to phase_len_i do not affect the current phase.
  - L==0 is treated as 1.
  - phase_active_o stays high for exactly max(L,1) cycles.
  - phase_done_o is high in the last of those cycles, with phase_idx_o still showing that phase.
- RUN, phase advance: the next edge increments phase_idx_o and loads the next length. There are no gap cycles, so phase_active_o stays high across the boundary.
- RUN, completion: after phase NUM_PHASES-1 completes, state goes to DONE.
  - all_done_o=1, busy_o=0, phase_active_o=0.
  - phase_idx_o holds the last index.
- Watchdog:
  - Counts every RUN cycle starting from 1 on the first RUN cycle.
  - If the count reaches TIMEOUT without completion, state goes to TIMEOUT at the next edge: timeout_o=1, busy_o=0, phase_active_o=0.
  - If completion and timeout fall on the same cycle, completion wins (DONE, timeout_o=0).
- abort_i in RUN: state goes to IDLE at the next edge.
  - busy_o=0, phase_active_o=0, phase_idx_o=0; no done or timeout flag is set.
  - abort_i has priority over completion and timeout in the same cycle.
- DONE/TIMEOUT: flags stay sticky. start_i==1 relaunches as from IDLE and clears both flags. abort_i is ignored.
- start_i in RUN is ignored.
- rst_n low mid-run: state immediately returns to HOLD. core_rst_n_o drops at that same edge.
- Counter widths:
  - Phase counter is CNT_W.
  - Watchdog is $clog2(TIMEOUT+1).
  - Hold counter is $clog2(RST_HOLD+1).
  - No counter wraps; each saturates at its terminal value.

Optional Feature:
PHASE_SEQ_STATS_EN
- Defined: adds output run_cycles_o [31:0]. It counts RUN cycles of the current or last run, clears at launch and freezes on DONE/TIMEOUT/abort. Also adds output run_count_o [15:0], which increments at each transition to DONE and saturates at 16'hFFFF. Both outputs are 0 in reset.
- Undefined: neither port nor its counters exist. All other behaviour is identical.

Decomposition:
- Package phase_seq_pkg holds:
  - state enum: HOLD, IDLE, RUN, DONE, TIMEOUT
  - default CNT_W
  - a function extracting a phase length from the packed vector
- Sub-module phase_seq_wdog: a loadable saturating up-counter with clear/enable and a terminal-count flag. It is instantiated for the hold counter and the watchdog.

Test Plan:
- Reset, then rst_n=1 -> core_rst_n_o low for exactly 10 edges and high after the 10th. All other outputs are 0 throughout.
- Lengths {5,10,15}, start pulse -> phase_active_o high for 30 consecutive cycles. phase_done_o pulses at cycles 5, 15 and 30. all_done_o=1 at cycle 31 and busy_o=0.
- TIMEOUT=20, lengths {5,10,15} -> timeout_o=1 after cycle 20 with phase_idx_o=2. all_done_o stays 0. A later start relaunches with both flags cleared.
- Lengths {0,1,2} -> phases last 1, 1 and 2 cycles, with phase_done_o high on 3 of 4 cycles. Lengths changed mid-phase are ignored until the next phase entry.
- abort_i at cycle 7 of a run -> IDLE next edge, phase_idx_o=0, no flags set. Separately, abort_i and timeout on the same cycle -> IDLE with timeout_o=0.
- rst_n low during phase 1 -> core_rst_n_o=0 and state HOLD at that edge. With PHASE_SEQ_STATS_EN, two full {5,10,15} runs -> run_count_o=2 and run_cycles_o=30.
